uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame_pkg.sv | 25 ++
 rtl/uart_bit_timer.sv | 31 +++
 rtl/uart_tx_frame.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_frame.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_frame_pkg.sv
// Shared constants for the configurable UART transmitter: parity modes,
// FSM state encoding and standard (non-inverted) line levels.
package uart_tx_frame_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_START  = 3'd1;
    localparam logic [ST_W-1:0] ST_DATA   = 3'd2;
    localparam logic [ST_W-1:0] ST_PARITY = 3'd3;
    localparam logic [ST_W-1:0] ST_STOP   = 3'd4;

    // Standard polarity; line_lvl() applies the INVERT option on top
    localparam logic LVL_IDLE  = 1'b1;
    localparam logic LVL_START = 1'b0;
    localparam logic LVL_STOP  = 1'b1;

    function automatic logic line_lvl(input logic invert, input logic lvl);
        return lvl ^ invert;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: loaded at each bit start, ticks on the last cycle
// of the period. Also reports whether the following cycle will be a tick.
module uart_bit_timer
    import uart_tx_frame_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [DIV_WIDTH-1:0] i_divisor,
    output logic                 o_tick_c,
    output logic                 o_tick_nxt_c
);

    logic [DIV_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_divisor;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - DIV_WIDTH'(1);
        end
    end

    assign o_tick_c     = (r_cnt == '0);
    assign o_tick_nxt_c = i_load ? (i_divisor == '0) : (r_cnt <= DIV_WIDTH'(1));

endmodule

// File: rtl/uart_tx_frame.sv
// Configurable UART transmitter with a one-word holding register so frames
// can be chained with no idle gap. All outputs are registered.
module uart_tx_frame
    import uart_tx_frame_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned INVERT    = 1
) (
    input  logic                 ref_clk,
    input  logic                 reset_n,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] in,
    output logic                 full,
    output logic                 busy,
    output logic                 done,
    output logic                 out
);

    localparam int unsigned IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic        P_INV     = 1'(INVERT);
    localparam logic        P_HAS_PAR = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
    localparam logic        P_ODD     = (PARITY == PAR_ODD);

    logic [ST_W-1:0]      r_state,    w_state_nxt;
    logic [DATA_BITS-1:0] r_hold,     w_hold_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic [IDX_W-1:0]     r_bit_idx,  w_bit_idx_nxt;
    logic [DIV_WIDTH-1:0] r_div,      w_div_nxt;
    logic                 r_full,     w_full_nxt;
    logic                 r_stop_idx, w_stop_idx_nxt;
    logic                 r_par,      w_par_nxt;
    logic                 r_out,      w_out_nxt;
    logic                 r_done,     w_done_nxt;
    logic                 r_busy;

    logic                 w_tick;
    logic                 w_tick_nxt;
    logic                 w_last_stop;
    logic                 w_launch;
    logic                 w_load;
    logic [DIV_WIDTH-1:0] w_load_val;

    // A launch happens from IDLE or straight out of the final stop bit
    assign w_last_stop = (r_stop_idx == 1'(STOP_BITS - 1));
    assign w_launch    = r_full && ((r_state == ST_IDLE) ||
                                    ((r_state == ST_STOP) && w_tick && w_last_stop));
    assign w_load      = w_launch || ((r_state != ST_IDLE) && w_tick);
    assign w_load_val  = w_launch ? divisor : r_div;

    uart_bit_timer #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_bit_timer (
        .clk          (ref_clk),
        .rst_n        (reset_n),
        .i_load       (w_load),
        .i_divisor    (w_load_val),
        .o_tick_c     (w_tick),
        .o_tick_nxt_c (w_tick_nxt)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_nxt     = r_hold;
        w_full_nxt     = r_full;
        w_shift_nxt    = r_shift;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_div_nxt      = r_div;
        w_par_nxt      = r_par;
        w_out_nxt      = line_lvl(P_INV, LVL_IDLE);
        w_done_nxt     = 1'b0;

        if (send && !r_full) begin
            w_hold_nxt = in;
            w_full_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: ;
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_idx_nxt = '0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        w_state_nxt    = P_HAS_PAR ? ST_PARITY : ST_STOP;
                        w_stop_idx_nxt = 1'b0;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt    = ST_STOP;
                    w_stop_idx_nxt = 1'b0;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (w_last_stop) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_launch) begin
            w_state_nxt = ST_START;
            w_shift_nxt = r_hold;
            w_div_nxt   = divisor;
            w_par_nxt   = P_ODD ? ~(^r_hold) : (^r_hold);
            w_full_nxt  = 1'b0;
        end

        // Outputs are computed from next-state values so they can be registered
        case (w_state_nxt)
            ST_START:  w_out_nxt = line_lvl(P_INV, LVL_START);
            ST_DATA:   w_out_nxt = line_lvl(P_INV, w_shift_nxt[0]);
            ST_PARITY: w_out_nxt = line_lvl(P_INV, w_par_nxt);
            ST_STOP:   w_out_nxt = line_lvl(P_INV, LVL_STOP);
            default:   w_out_nxt = line_lvl(P_INV, LVL_IDLE);
        endcase
        w_done_nxt = (w_state_nxt == ST_STOP) &&
                     (w_stop_idx_nxt == 1'(STOP_BITS - 1)) && w_tick_nxt;
    end

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_hold     <= '0;
            r_full     <= 1'b0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_div      <= '0;
            r_par      <= 1'b0;
            r_out      <= line_lvl(P_INV, LVL_IDLE);
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_full     <= w_full_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_div      <= w_div_nxt;
            r_par      <= w_par_nxt;
            r_out      <= w_out_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= w_done_nxt;
        end
    end

    assign full = r_full;
    assign busy = r_busy;
    assign done = r_done;
    assign out  = r_out;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: default 8N1-inverted instance plus a 7E2 standard
// instance, checked cycle by cycle against a bit-list frame model.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1_n, send1, full1, busy1, done1, out1;
    logic [15:0] div1;
    logic [7:0]  in1;
    logic        rst2_n, send2, full2, busy2, done2, out2;
    logic [15:0] div2;
    logic [6:0]  in2;

    uart_tx_frame u_dut1 (
        .ref_clk (clk), .reset_n (rst1_n), .divisor (div1), .send (send1),
        .in (in1), .full (full1), .busy (busy1), .done (done1), .out (out1)
    );

    uart_tx_frame #(
        .DATA_BITS (7), .PARITY (2), .STOP_BITS (2), .DIV_WIDTH (16), .INVERT (0)
    ) u_dut2 (
        .ref_clk (clk), .reset_n (rst2_n), .divisor (div2), .send (send2),
        .in (in2), .full (full2), .busy (busy2), .done (done2), .out (out2)
    );

    int total = 0;
    int bad   = 0;

    // Per-cycle {out, busy, done} samples and expectations
    logic [2:0] obs_q[$];
    logic [2:0] exp_q[$];
    logic       full_q[$];

    task automatic clear_q();
        obs_q.delete();
        exp_q.delete();
        full_q.delete();
    endtask

    task automatic step(input int n, input int sel);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sel == 0) begin
                obs_q.push_back({out1, busy1, done1});
                full_q.push_back(full1);
            end else begin
                obs_q.push_back({out2, busy2, done2});
                full_q.push_back(full2);
            end
        end
    endtask

    task automatic model_idle(input int n, input int inv);
        for (int i = 0; i < n; i++) exp_q.push_back({(inv == 0), 1'b0, 1'b0});
    endtask

    // Frame as a list of standard-polarity bits, each held div+1 cycles
    task automatic model_frame(input int dbits, input int par, input int stops,
                               input int inv, input logic [31:0] word, input int div);
        logic b[$];
        int   ones;
        ones = 0;
        b.push_back(1'b0);
        for (int i = 0; i < dbits; i++) begin
            b.push_back(word[i]);
            ones = ones + (word[i] ? 1 : 0);
        end
        if (par == 1) b.push_back((ones % 2) == 0);
        if (par == 2) b.push_back((ones % 2) == 1);
        for (int s = 0; s < stops; s++) b.push_back(1'b1);
        for (int k = 0; k < b.size(); k++) begin
            for (int c = 0; c <= div; c++) begin
                exp_q.push_back({b[k] ^ (inv != 0), 1'b1, (k == b.size() - 1) && (c == div)});
            end
        end
    endtask

    task automatic test_reset();
        rst1_n = 1'b0; rst2_n = 1'b0;
        send1 = 1'b0; send2 = 1'b0; in1 = '0; in2 = '0; div1 = 16'd3; div2 = 16'd1;
        repeat (3) @(negedge clk);
        total++; if (out1 !== 1'b0) begin bad++; $display("FAIL reset_out1 got %b exp 0", out1); end
        total++; if ({busy1, full1, done1} !== 3'b000) begin bad++; $display("FAIL reset_flags1 got %b exp 000", {busy1, full1, done1}); end
        total++; if (out2 !== 1'b1) begin bad++; $display("FAIL reset_out2 got %b exp 1", out2); end
        total++; if ({busy2, full2, done2} !== 3'b000) begin bad++; $display("FAIL reset_flags2 got %b exp 000", {busy2, full2, done2}); end
        rst1_n = 1'b1; rst2_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        clear_q();
        model_idle(1, 1); model_frame(8, 0, 1, 1, 32'hA9, 3); model_idle(3, 1);
        @(negedge clk); div1 = 16'd3; send1 = 1'b1; in1 = 8'hA9;
        step(1, 0); send1 = 1'b0;
        step(exp_q.size() - obs_q.size(), 0);
        total++; if (full_q[0] !== 1'b1) begin bad++; $display("FAIL basic_full got %b exp 1", full_q[0]); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic cyc %0d {out,busy,done} got %b exp %b", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        model_idle(1, 1); model_frame(8, 0, 1, 1, 32'h5A, 0); model_frame(8, 0, 1, 1, 32'hC3, 0); model_idle(2, 1);
        @(negedge clk); div1 = 16'd0; send1 = 1'b1; in1 = 8'h5A;
        step(1, 0); send1 = 1'b0;
        step(1, 0); send1 = 1'b1; in1 = 8'hC3;
        step(1, 0); send1 = 1'b0;
        step(exp_q.size() - obs_q.size(), 0);
        for (int i = 2; i <= 10; i++) begin
            total++; if (full_q[i] !== 1'b1) begin bad++; $display("FAIL b2b_full cyc %0d got %b exp 1", i, full_q[i]); end
        end
        total++; if (full_q[11] !== 1'b0) begin bad++; $display("FAIL b2b_full_drop got %b exp 0", full_q[11]); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b cyc %0d {out,busy,done} got %b exp %b", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_full_drop();
        clear_q();
        model_idle(1, 1); model_frame(8, 0, 1, 1, 32'h3C, 1); model_frame(8, 0, 1, 1, 32'hB2, 1); model_idle(4, 1);
        @(negedge clk); div1 = 16'd1; send1 = 1'b1; in1 = 8'h3C;
        step(1, 0); send1 = 1'b0;
        step(1, 0); send1 = 1'b1; in1 = 8'hB2;
        step(1, 0); in1 = 8'h11;
        step(1, 0); in1 = 8'h22;
        step(1, 0); send1 = 1'b0;
        step(exp_q.size() - obs_q.size(), 0);
        total++; if ({full_q[2], full_q[3]} !== 2'b11) begin bad++; $display("FAIL drop_full got %b exp 11", {full_q[2], full_q[3]}); end
        total++; if (full_q[full_q.size() - 1] !== 1'b0) begin bad++; $display("FAIL drop_full_end got %b exp 0", full_q[full_q.size() - 1]); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL drop cyc %0d {out,busy,done} got %b exp %b", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_parity_cfg();
        clear_q();
        model_idle(1, 0); model_frame(7, 2, 2, 0, 32'h4B, 1); model_idle(2, 0);
        @(negedge clk); div2 = 16'd1; send2 = 1'b1; in2 = 7'h4B;
        step(1, 1); send2 = 1'b0;
        step(exp_q.size() - obs_q.size(), 1);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL par7e2 cyc %0d {out,busy,done} got %b exp %b", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        @(negedge clk); div1 = 16'd3; send1 = 1'b1; in1 = 8'hF0;
        step(1, 0); send1 = 1'b0;
        step(1, 0); send1 = 1'b1; in1 = 8'h77;
        step(1, 0); send1 = 1'b0;
        step(6, 0);
        total++; if (out1 !== 1'b1) begin bad++; $display("FAIL rst_mid_pre out got %b exp 1", out1); end
        #2 rst1_n = 1'b0;
        #1;
        total++; if (out1 !== 1'b0) begin bad++; $display("FAIL rst_mid_out got %b exp 0", out1); end
        total++; if ({busy1, full1} !== 2'b00) begin bad++; $display("FAIL rst_mid_flags got %b exp 00", {busy1, full1}); end
        #1 rst1_n = 1'b1;
        clear_q();
        model_idle(1, 1); model_frame(8, 0, 1, 1, 32'h4B, 3); model_idle(3, 1);
        @(negedge clk); send1 = 1'b1; in1 = 8'h4B;
        step(1, 0); send1 = 1'b0;
        step(exp_q.size() - obs_q.size(), 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rst_after cyc %0d {out,busy,done} got %b exp %b", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_div_change();
        clear_q();
        model_idle(1, 1); model_frame(8, 0, 1, 1, 32'h96, 3); model_frame(8, 0, 1, 1, 32'h69, 1); model_idle(2, 1);
        @(negedge clk); div1 = 16'd3; send1 = 1'b1; in1 = 8'h96;
        step(1, 0); send1 = 1'b0;
        step(1, 0); send1 = 1'b1; in1 = 8'h69; div1 = 16'd1;
        step(1, 0); send1 = 1'b0;
        step(exp_q.size() - obs_q.size(), 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL divchg cyc %0d {out,busy,done} got %b exp %b", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] w1, w2;
        logic [6:0] w3;
        int         d1, d2;
        for (int it = 0; it < 4; it++) begin
            w1 = 8'($urandom_range(0, 255)); w2 = 8'($urandom_range(0, 255));
            d1 = int'($urandom_range(0, 3));  d2 = int'($urandom_range(0, 3));
            clear_q();
            model_idle(1, 1); model_frame(8, 0, 1, 1, 32'(w1), d1); model_frame(8, 0, 1, 1, 32'(w2), d2); model_idle(2, 1);
            @(negedge clk); div1 = 16'(d1); send1 = 1'b1; in1 = w1;
            step(1, 0); send1 = 1'b0;
            step(1, 0); send1 = 1'b1; in1 = w2; div1 = 16'(d2);
            step(1, 0); send1 = 1'b0;
            step(exp_q.size() - obs_q.size(), 0);
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand8 it %0d cyc %0d got %b exp %b", it, i, obs_q[i], exp_q[i]); end
            end
        end
        for (int it = 0; it < 3; it++) begin
            w3 = 7'($urandom_range(0, 127));
            d1 = int'($urandom_range(0, 2));
            clear_q();
            model_idle(1, 0); model_frame(7, 2, 2, 0, 32'(w3), d1); model_idle(2, 0);
            @(negedge clk); div2 = 16'(d1); send2 = 1'b1; in2 = w3;
            step(1, 1); send2 = 1'b0;
            step(exp_q.size() - obs_q.size(), 1);
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand7 it %0d cyc %0d got %b exp %b", it, i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_full_drop();
        test_parity_cfg();
        test_reset_mid();
        test_div_change();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
